uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Framed, parametrised UART command controller for the Colorlight i9 LED/control path. It sits between the uart_top byte interface and an N-bit output register. It accepts checksummed 4-byte command frames with inter-byte timeout, executes bit-level and bar-graph LED operations, and returns a 2-byte status response. It replaces the single-byte command/fixed-ACK scheme with error detection, NAK reporting and a saturating error counter.

Parameters:
NUM_LEDS, 4, width of led_out (1..8)
CLK_FREQ_HZ, 25_000_000, frequency of clk_50mhz (the board oscillator is 25 MHz)
BYTE_TIMEOUT_US, 1000, maximum allowed gap between bytes of one frame
SOF_BYTE, 8'h55, start-of-frame marker
ACK_BYTE, 8'hAA, success status
NAK_BYTE, 8'hEE, failure status

Ports:
clk_50mhz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx_dv  in  1  one-cycle strobe from uart_top: rx_byte is valid
rx_byte  in  8  received byte
tx_active  in  1  uart_top transmitter busy
tx_done  in  1  one-cycle pulse when a byte has finished transmitting
tx_dv  out  1  one-cycle request to transmit tx_byte
tx_byte  out  8  byte to transmit
led_out  out  NUM_LEDS  controlled output register
frame_err_cnt  out  8  saturating count of bad frames (checksum, timeout, bad command)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-low on reset_n; the design is clocked on the rising edge of clk_50mhz.
- Reset values: led_out=0, tx_dv=0, tx_byte=0, frame_err_cnt=0, busy=0, state=IDLE, timeout counter=0.
- Frame format: SOF, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- State machine:
  - IDLE: on rx_dv with rx_byte==SOF_BYTE go to GET_CMD. Any other byte is silently discarded (no error count).
  - GET_CMD, GET_ARG, GET_CHK: each latches rx_byte on rx_dv and advances.
  - EXEC (1 cycle), then TX0, W0, TX1, W1, then IDLE.
- Timeout:
  - TO_CLKS = CLK_FREQ_HZ/1_000_000*BYTE_TIMEOUT_US.
  - The counter clears on every rx_dv and on entry to GET_CMD.
  - If it reaches TO_CLKS in any GET_* state: increment frame_err_cnt, return to IDLE, send no response.
- EXEC:
  - Checksum mismatch: status=NAK, data=8'h01, led_out unchanged, error counted.
  - Otherwise decode CMD:
    - 0x01 SET: led_out <= ARG[NUM_LEDS-1:0].
    - 0x02 SETBIT: led_out[ARG] <= 1.
    - 0x03 CLRBIT: led_out[ARG] <= 0.
    - 0x04 TOGGLE: led_out <= ~led_out.
    - 0x05 BAR: lowest min(ARG,NUM_LEDS) bits set, the rest clear. ARG=0 clears all; ARG>NUM_LEDS saturates to all ones.
  - SETBIT/CLRBIT with ARG>=NUM_LEDS: NAK, data=8'h02, no change, error counted.
  - Unknown CMD: NAK, data=8'h03, error counted.
  - Success: status=ACK, data=CMD echo.
- led_out updates on the clock edge leaving EXEC. Latency from the CHK rx_dv to the led_out change is 2 cycles.
- Transmit handshake:
  - TX0 waits for tx_active==0, then drives tx_dv=1 for exactly one cycle with tx_byte=status.
  - W0 waits for tx_done.
  - TX1 and W1 do the same for the data byte.
  - tx_byte holds its value until the next load.
- rx_dv arriving in EXEC, TX* or W* is dropped. It is not counted as an error and not queued.
- frame_err_cnt saturates at 8'hFF.
- A reset assertion mid-frame or mid-response aborts immediately: tx_dv=0 and all outputs return to reset values. A byte already in flight in uart_top is not the responsibility of this block.

Optional Feature:
UART_CMD_READBACK_EN
- Defined: CMD 0x06 GET is legal. It responds ACK, then data = zero-extended led_out, with no state change. ARG is ignored but the checksum is still checked.
- Undefined: 0x06 is treated as an unknown command (NAK, 8'h03, error counted).

Test Plan:
- Reset, then frame 55 01 05 04 -> led_out=4'b0101, bytes AA 01 sent, frame_err_cnt=0.
- Frame 55 05 09 0C with NUM_LEDS=4 -> led_out=4'b1111, response AA 05. Then frame 55 05 00 05 -> led_out=0.
- Frame 55 02 07 00 (bad checksum) -> NAK 01, led_out unchanged, frame_err_cnt=1. Frame 55 02 07 05 -> NAK 02 (bit out of range), frame_err_cnt=2.
- Send 55 01, then idle longer than TO_CLKS -> no tx_dv, state IDLE, frame_err_cnt+1. A following valid frame executes normally.
- Hold tx_active=1 during TX0 for 100 cycles -> tx_dv stays 0; it pulses once, one cycle after tx_active falls. Extra rx_dv during W0 is ignored.
- With UART_CMD_READBACK_EN: after SET 0x0A, frame 55 06 00 06 -> AA 0A. Without the macro -> EE 03.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command controller: SOF/CMD/ARG/CHK frames drive an LED register, with a 2-byte status reply.
// Optional `UART_CMD_READBACK_EN` adds CMD 0x06 (GET) returning the current led_out value.
module uart_cmd_ctrl #(
    parameter int          NUM_LEDS        = 4,
    parameter int          CLK_FREQ_HZ     = 25_000_000,
    parameter int          BYTE_TIMEOUT_US = 1000,
    parameter logic [7:0]  SOF_BYTE        = 8'h55,
    parameter logic [7:0]  ACK_BYTE        = 8'hAA,
    parameter logic [7:0]  NAK_BYTE        = 8'hEE
) (
    input  logic                clk_50mhz,
    input  logic                reset_n,
    input  logic                rx_dv,
    input  logic [7:0]          rx_byte,
    input  logic                tx_active,
    input  logic                tx_done,
    output logic                tx_dv,
    output logic [7:0]          tx_byte,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [7:0]          frame_err_cnt,
    output logic                busy
);

    // state   | meaning
    // IDLE    | hunting for SOF, other bytes discarded
    // GET_CMD | waiting for command byte (timeout armed)
    // GET_ARG | waiting for argument byte (timeout armed)
    // GET_CHK | waiting for checksum byte (timeout armed)
    // EXEC    | decode frame, update led_out, latch status/data
    // TX0/W0  | send status byte, wait for tx_done
    // TX1/W1  | send data byte, wait for tx_done
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_GET_CMD = 4'd1;
    localparam logic [3:0] S_GET_ARG = 4'd2;
    localparam logic [3:0] S_GET_CHK = 4'd3;
    localparam logic [3:0] S_EXEC    = 4'd4;
    localparam logic [3:0] S_TX0     = 4'd5;
    localparam logic [3:0] S_W0      = 4'd6;
    localparam logic [3:0] S_TX1     = 4'd7;
    localparam logic [3:0] S_W1      = 4'd8;

    localparam int TO_CLKS = CLK_FREQ_HZ / 1_000_000 * BYTE_TIMEOUT_US;
    localparam int TO_W    = $clog2(TO_CLKS + 1);

    logic [3:0]          state_q, state_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [7:0]          cmd_q, cmd_d, arg_q, arg_d, chk_q, chk_d;
    logic [7:0]          status_q, status_d, data_q, data_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [7:0]          err_q, err_d;
    logic                err_inc;

    logic [7:0]          ex_status, ex_data;
    logic [NUM_LEDS-1:0] ex_led, bit_mask, bar_mask;
    logic                ex_err, arg_in_range;

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            bit_mask[i] = (arg_q == 8'(i));
            bar_mask[i] = (arg_q > 8'(i));
        end
        arg_in_range = (arg_q < 8'(NUM_LEDS));
        ex_status    = ACK_BYTE;
        ex_data      = cmd_q;
        ex_led       = led_q;
        ex_err       = 1'b0;
        if (chk_q != (cmd_q ^ arg_q)) begin
            ex_status = NAK_BYTE;
            ex_data   = 8'h01;
            ex_err    = 1'b1;
        end else begin
            case (cmd_q)
                8'h01: ex_led = arg_q[NUM_LEDS-1:0];
                8'h02, 8'h03: begin
                    if (!arg_in_range) begin
                        ex_status = NAK_BYTE;
                        ex_data   = 8'h02;
                        ex_err    = 1'b1;
                    end else if (cmd_q == 8'h02) begin
                        ex_led = led_q | bit_mask;
                    end else begin
                        ex_led = led_q & ~bit_mask;
                    end
                end
                8'h04: ex_led = ~led_q;
                8'h05: ex_led = bar_mask;
`ifdef UART_CMD_READBACK_EN
                8'h06: ex_data = 8'(led_q);
`endif
                default: begin
                    ex_status = NAK_BYTE;
                    ex_data   = 8'h03;
                    ex_err    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        chk_d     = chk_q;
        status_d  = status_q;
        data_d    = data_q;
        led_d     = led_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        err_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_dv && rx_byte == SOF_BYTE) begin
                    state_d  = S_GET_CMD;
                    to_cnt_d = '0;
                end
            end
            S_GET_CMD, S_GET_ARG, S_GET_CHK: begin
                if (rx_dv) begin
                    to_cnt_d = '0;
                    if (state_q == S_GET_CMD) begin
                        cmd_d   = rx_byte;
                        state_d = S_GET_ARG;
                    end else if (state_q == S_GET_ARG) begin
                        arg_d   = rx_byte;
                        state_d = S_GET_CHK;
                    end else begin
                        chk_d   = rx_byte;
                        state_d = S_EXEC;
                    end
                end else if (to_cnt_q == TO_W'(TO_CLKS)) begin
                    err_inc  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                status_d = ex_status;
                data_d   = ex_data;
                led_d    = ex_led;
                err_inc  = ex_err;
                state_d  = S_TX0;
            end
            S_TX0: begin
                if (!tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = status_q;
                    state_d   = S_W0;
                end
            end
            S_W0: if (tx_done) state_d = S_TX1;
            S_TX1: begin
                if (!tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = data_q;
                    state_d   = S_W1;
                end
            end
            S_W1: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            chk_q     <= '0;
            status_q  <= '0;
            data_q    <= '0;
            led_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            chk_q     <= chk_d;
            status_q  <= status_d;
            data_q    <= data_d;
            led_q     <= led_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            err_q     <= err_d;
        end
    end

    assign tx_dv         = tx_dv_q;
    assign tx_byte       = tx_byte_q;
    assign led_out       = led_q;
    assign frame_err_cnt = err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: constant vector table, hand-written corner sequences and random frames vs a reference model.
// Honours `UART_CMD_READBACK_EN` when computing expectations for CMD 0x06.
module tb_uart_cmd_ctrl;
    localparam int N = 4;

    logic         clk_50mhz = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_dv = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         tx_active;
    logic         tx_done = 1'b0;
    logic         tx_dv;
    logic [7:0]   tx_byte;
    logic [N-1:0] led_out;
    logic [7:0]   frame_err_cnt;
    logic         busy;
    logic         model_act = 1'b0;
    logic         hold_active = 1'b0;

    assign tx_active = model_act | hold_active;
    always #5 clk_50mhz = ~clk_50mhz;

    uart_cmd_ctrl #(
        .NUM_LEDS(N), .CLK_FREQ_HZ(1_000_000), .BYTE_TIMEOUT_US(50),
        .SOF_BYTE(8'h55), .ACK_BYTE(8'hAA), .NAK_BYTE(8'hEE)
    ) dut (
        .clk_50mhz(clk_50mhz), .reset_n(reset_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .led_out(led_out), .frame_err_cnt(frame_err_cnt), .busy(busy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int txdv_cycles = 0;
    logic [7:0] rsp_q[$];
    logic [N-1:0] m_led;
    logic [7:0]   m_err;

    typedef struct packed {
        logic [7:0] cmd, arg, chk;
        logic [3:0] led;
        logic [7:0] st, dat, err;
    } vec_t;
    vec_t tbl [15];

`ifdef UART_CMD_READBACK_EN
    localparam logic [7:0] RB_ST = 8'hAA, RB_DAT = 8'h0A, E13 = 8'd4;
`else
    localparam logic [7:0] RB_ST = 8'hEE, RB_DAT = 8'h03, E13 = 8'd5;
`endif

    always @(negedge clk_50mhz) if (tx_dv === 1'b1) txdv_cycles++;

    // Transmitter stand-in: capture each requested byte, stay busy a few cycles, then pulse tx_done.
    initial begin
        forever begin
            @(posedge clk_50mhz); #1;
            if (tx_dv === 1'b1) begin
                rsp_q.push_back(tx_byte);
                model_act = 1'b1;
                repeat (3) @(posedge clk_50mhz);
                #1; model_act = 1'b0; tx_done = 1'b1;
                @(posedge clk_50mhz); #1; tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_50mhz); #1;
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk_50mhz); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
        send_byte(8'h55); send_byte(cmd); send_byte(arg); send_byte(chk);
    endtask

    task automatic wait_resp(input string name);
        int k = 0;
        while (!(rsp_q.size() >= 2 && busy === 1'b0) && k < 400) begin
            @(negedge clk_50mhz); k++;
        end
        if (k >= 400) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_resp_wait: got %0d bytes, want 2 bytes and idle", name, rsp_q.size());
        end
    endtask

    task automatic check_resp(input string name, input logic [7:0] st, input logic [7:0] dat);
        logic [7:0] a0 = 8'hxx;
        logic [7:0] a1 = 8'hxx;
        if (rsp_q.size() > 0) a0 = rsp_q.pop_front();
        if (rsp_q.size() > 0) a1 = rsp_q.pop_front();
        check({name, "_status"}, {24'h0, a0}, {24'h0, st});
        check({name, "_data"}, {24'h0, a1}, {24'h0, dat});
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] arg,
                             input logic [7:0] chk, input logic [N-1:0] e_led, input logic [7:0] e_st,
                             input logic [7:0] e_dat, input logic [7:0] e_err);
        int c0;
        rsp_q.delete();
        c0 = txdv_cycles;
        send_frame(cmd, arg, chk);
        wait_resp(name);
        check_resp(name, e_st, e_dat);
        check({name, "_led"}, 32'(led_out), 32'(e_led));
        check({name, "_errcnt"}, 32'(frame_err_cnt), 32'(e_err));
        check({name, "_txdv_cycles"}, 32'(txdv_cycles - c0), 32'd2);
    endtask

    function automatic void ref_exec(input logic [N-1:0] led, input logic [7:0] cmd, input logic [7:0] arg,
                                     input logic [7:0] chk, output logic [N-1:0] nled,
                                     output logic [7:0] st, output logic [7:0] dat, output bit bad);
        int a = int'(arg);
        nled = led; st = 8'hAA; dat = cmd; bad = 1'b0;
        if ((cmd ^ arg) != chk) begin
            st = 8'hEE; dat = 8'h01; bad = 1'b1;
        end else begin
            case (cmd)
                8'h01: nled = arg[N-1:0];
                8'h02, 8'h03: begin
                    if (a >= N) begin
                        st = 8'hEE; dat = 8'h02; bad = 1'b1;
                    end else if (cmd == 8'h02) begin
                        nled = led | N'(1 << a);
                    end else begin
                        nled = led & ~N'(1 << a);
                    end
                end
                8'h04: nled = ~led;
                8'h05: nled = N'((1 << (a < N ? a : N)) - 1);
`ifdef UART_CMD_READBACK_EN
                8'h06: dat = 8'(led);
`endif
                default: begin
                    st = 8'hEE; dat = 8'h03; bad = 1'b1;
                end
            endcase
        end
    endfunction

    initial begin
        logic [N-1:0] nled;
        logic [7:0]   st, dat, cmd, arg, chk;
        bit           bad;
        int           c0, k;

        tbl[0]  = '{8'h05, 8'h09, 8'h0C, 4'hF, 8'hAA, 8'h05, 8'd0};
        tbl[1]  = '{8'h05, 8'h00, 8'h05, 4'h0, 8'hAA, 8'h05, 8'd0};
        tbl[2]  = '{8'h02, 8'h07, 8'h00, 4'h0, 8'hEE, 8'h01, 8'd1};
        tbl[3]  = '{8'h02, 8'h07, 8'h05, 4'h0, 8'hEE, 8'h02, 8'd2};
        tbl[4]  = '{8'h02, 8'h02, 8'h00, 4'h4, 8'hAA, 8'h02, 8'd2};
        tbl[5]  = '{8'h03, 8'h02, 8'h01, 4'h0, 8'hAA, 8'h03, 8'd2};
        tbl[6]  = '{8'h04, 8'h00, 8'h04, 4'hF, 8'hAA, 8'h04, 8'd2};
        tbl[7]  = '{8'h07, 8'h00, 8'h07, 4'hF, 8'hEE, 8'h03, 8'd3};
        tbl[8]  = '{8'h05, 8'h02, 8'h07, 4'h3, 8'hAA, 8'h05, 8'd3};
        tbl[9]  = '{8'h03, 8'h04, 8'h07, 4'h3, 8'hEE, 8'h02, 8'd4};
        tbl[10] = '{8'h02, 8'h03, 8'h01, 4'hB, 8'hAA, 8'h02, 8'd4};
        tbl[11] = '{8'h01, 8'h0A, 8'h0B, 4'hA, 8'hAA, 8'h01, 8'd4};
        tbl[12] = '{8'h06, 8'h00, 8'h06, 4'hA, RB_ST, RB_DAT, E13};
        tbl[13] = '{8'h05, 8'h04, 8'h01, 4'hF, 8'hAA, 8'h05, E13};
        tbl[14] = '{8'h01, 8'h00, 8'h02, 4'hF, 8'hEE, 8'h01, E13 + 8'd1};

        repeat (3) @(posedge clk_50mhz);
        #1;
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_txdv", 32'(tx_dv), 32'h0);
        check("rst_txbyte", 32'(tx_byte), 32'h0);
        check("rst_errcnt", 32'(frame_err_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;

        // First frame with a cycle-accurate look at the led_out update latency.
        rsp_q.delete();
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h05); send_byte(8'h04);
        @(negedge clk_50mhz);
        check("lat_led_cycle1", 32'(led_out), 32'h0);
        @(negedge clk_50mhz);
        check("lat_led_cycle2", 32'(led_out), 32'h5);
        wait_resp("first");
        check_resp("first", 8'hAA, 8'h01);
        check("first_errcnt", 32'(frame_err_cnt), 32'h0);

        for (int i = 0; i < 15; i++)
            run_frame($sformatf("row%0d", i), tbl[i].cmd, tbl[i].arg, tbl[i].chk,
                      tbl[i].led[N-1:0], tbl[i].st, tbl[i].dat, tbl[i].err);
        m_led = tbl[14].led[N-1:0];
        m_err = tbl[14].err;

        // Inter-byte timeout: frame abandoned, no reply, error counted.
        rsp_q.delete();
        c0 = txdv_cycles;
        send_byte(8'h55); send_byte(8'h01);
        repeat (80) @(negedge clk_50mhz);
        check("to_no_txdv", 32'(txdv_cycles - c0), 32'd0);
        check("to_no_bytes", 32'(rsp_q.size()), 32'd0);
        check("to_idle", 32'(busy), 32'h0);
        m_err = m_err + 8'd1;
        check("to_errcnt", 32'(frame_err_cnt), 32'(m_err));
        check("to_led_kept", 32'(led_out), 32'(m_led));
        run_frame("after_to", 8'h01, 8'h0C, 8'h0D, 4'hC, 8'hAA, 8'h01, m_err);
        m_led = 4'hC;

        // Transmitter busy holds off tx_dv; a byte arriving during W0 is dropped.
        rsp_q.delete();
        c0 = txdv_cycles;
        hold_active = 1'b1;
        send_frame(8'h01, 8'h06, 8'h07);
        repeat (100) @(negedge clk_50mhz);
        check("hold_no_txdv", 32'(txdv_cycles - c0), 32'd0);
        check("hold_busy", 32'(busy), 32'h1);
        @(posedge clk_50mhz); #1;
        hold_active = 1'b0;
        @(negedge clk_50mhz);
        check("release_txdv_low", 32'(tx_dv), 32'h0);
        @(negedge clk_50mhz);
        check("release_txdv_high", 32'(tx_dv), 32'h1);
        send_byte(8'h55);
        wait_resp("hold");
        check_resp("hold", 8'hAA, 8'h01);
        check("hold_txdv_cycles", 32'(txdv_cycles - c0), 32'd2);
        m_led = 4'h6;
        repeat (80) @(negedge clk_50mhz);
        check("w0_rx_ignored_busy", 32'(busy), 32'h0);
        check("w0_rx_ignored_err", 32'(frame_err_cnt), 32'(m_err));
        check("hold_led", 32'(led_out), 32'(m_led));

        for (int i = 0; i < 40; i++) begin
            cmd = 8'($urandom_range(0, 7));
            arg = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            chk = cmd ^ arg;
            if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            ref_exec(m_led, cmd, arg, chk, nled, st, dat, bad);
            if (bad) m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
            m_led = nled;
            run_frame($sformatf("rnd%0d", i), cmd, arg, chk, m_led, st, dat, m_err);
        end

        // Reset in the middle of the response aborts everything.
        rsp_q.delete();
        send_frame(8'h04, 8'h00, 8'h04);
        k = 0;
        while (rsp_q.size() < 1 && k < 200) begin
            @(negedge clk_50mhz); k++;
        end
        check("midrst_first_byte_seen", 32'(rsp_q.size() >= 1), 32'h1);
        @(negedge clk_50mhz);
        reset_n = 1'b0;
        #1;
        check("midrst_led", 32'(led_out), 32'h0);
        check("midrst_txdv", 32'(tx_dv), 32'h0);
        check("midrst_txbyte", 32'(tx_byte), 32'h0);
        check("midrst_errcnt", 32'(frame_err_cnt), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk_50mhz);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_50mhz);
        check("postrst_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
